// File: rtl/sseg4_decoder.sv
// Recovers the 4-digit value shown on a multiplexed, active-low seven-segment display.
// Digits are accepted after STABLE_CYCLES equal samples; a full frame is published with a one-cycle valid.
module sseg4_decoder #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  seg,
  input  logic        dp,
  input  logic [3:0]  an,
  output logic [15:0] data,
  output logic        sign,
  output logic        err,
  output logic        valid
);

  typedef enum logic {COLLECT, PUBLISH} state_t;

  typedef struct packed {
    logic       ok;
    logic [3:0] nib;
  } dec_t;

  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES);
  localparam logic [7:0] CNT_HIT = 8'(STABLE_CYCLES - 1);
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  function automatic dec_t decode_seg(input logic [6:0] s);
    dec_t r;
    r.ok = 1'b1;
    case (s)
      7'b1000000: r.nib = 4'h0;
      7'b1111001: r.nib = 4'h1;
      7'b0100100: r.nib = 4'h2;
      7'b0110000: r.nib = 4'h3;
      7'b0011001: r.nib = 4'h4;
      7'b0010010: r.nib = 4'h5;
      7'b0000010: r.nib = 4'h6;
      7'b1111000: r.nib = 4'h7;
      7'b0000000: r.nib = 4'h8;
      7'b0010000: r.nib = 4'h9;
      7'b0001000: r.nib = 4'hA;
      7'b0000011: r.nib = 4'hB;
      7'b1000110: r.nib = 4'hC;
      7'b0100001: r.nib = 4'hD;
      7'b0000110: r.nib = 4'hE;
      7'b0001110: r.nib = 4'hF;
      default: begin
        r.ok  = 1'b0;
        r.nib = 4'h0;
      end
    endcase
    return r;
  endfunction

  // The decimal point carries no information for the recovered value.
  logic unused_dp;
  assign unused_dp = dp;

  state_t      state_q, state_d;
  logic [6:0]  s_seg_q, s_seg_d;
  logic [3:0]  s_an_q, s_an_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  seen_q, seen_d;
  logic [15:0] pend_data_q, pend_data_d;
  logic        pend_sign_q, pend_sign_d;
  logic        pend_err_q, pend_err_d;
  logic [15:0] data_q, data_d;
  logic        sign_q, sign_d;
  logic        err_q, err_d;
  logic        valid_q, valid_d;

  logic        diff;
  logic        an_ok;
  logic [1:0]  digit;
  logic        commit;
  dec_t        dec;

  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    an_ok = 1'b1;
    digit = 2'd0;
    case (s_an_q)
      4'b1110: digit = 2'd0;
      4'b1101: digit = 2'd1;
      4'b1011: digit = 2'd2;
      4'b0111: digit = 2'd3;
      default: an_ok = 1'b0;
    endcase

    diff    = (seg != s_seg_q) || (an != s_an_q);
    s_seg_d = seg;
    s_an_d  = an;

    if (diff)                  cnt_d = 8'd0;
    else if (cnt_q == CNT_MAX) cnt_d = cnt_q;
    else                       cnt_d = cnt_q + 8'd1;

    // Saturation above CNT_HIT guarantees a single commit per stable period.
    commit = !diff && an_ok && (cnt_d == CNT_HIT);
    dec    = decode_seg(s_seg_q);

    seen_d      = seen_q;
    pend_data_d = pend_data_q;
    pend_sign_d = pend_sign_q;
    pend_err_d  = pend_err_q;

    if (state_q == PUBLISH) begin
      seen_d      = 4'h0;
      pend_sign_d = 1'b0;
      pend_err_d  = 1'b0;
    end

    // Applied after the clear so a commit during PUBLISH lands in the new frame.
    if (commit) begin
      seen_d[digit] = 1'b1;
      if (digit == 2'd3 && s_seg_q == SEG_MINUS) begin
        pend_data_d[{digit, 2'b00} +: 4] = 4'h0;
        pend_sign_d = 1'b1;
      end else begin
        if (digit == 2'd3) pend_sign_d = 1'b0;
        pend_data_d[{digit, 2'b00} +: 4] = dec.nib;
        if (!dec.ok) pend_err_d = 1'b1;
      end
    end

    state_d = COLLECT;
    if (state_q == COLLECT && seen_q == 4'hF) state_d = PUBLISH;

    data_d  = data_q;
    sign_d  = sign_q;
    err_d   = err_q;
    valid_d = (state_d == PUBLISH);
    if (state_d == PUBLISH) begin
      data_d = pend_data_d;
      sign_d = pend_sign_d;
      err_d  = pend_err_d;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= COLLECT;
      s_seg_q     <= 7'h7F;
      s_an_q      <= 4'hF;
      cnt_q       <= 8'd0;
      seen_q      <= 4'h0;
      pend_data_q <= 16'h0;
      pend_sign_q <= 1'b0;
      pend_err_q  <= 1'b0;
      data_q      <= 16'h0;
      sign_q      <= 1'b0;
      err_q       <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_seg_q     <= s_seg_d;
      s_an_q      <= s_an_d;
      cnt_q       <= cnt_d;
      seen_q      <= seen_d;
      pend_data_q <= pend_data_d;
      pend_sign_q <= pend_sign_d;
      pend_err_q  <= pend_err_d;
      data_q      <= data_d;
      sign_q      <= sign_d;
      err_q       <= err_d;
      valid_q     <= valid_d;
    end
  end

  assign data  = data_q;
  assign sign  = sign_q;
  assign err   = err_q;
  assign valid = valid_q;

endmodule

// File: doc/sseg4_decoder.md
SSEG4_DECODER -- requirements
Module: sseg4_decoder

Interface
REQ-001 The block SHALL have one parameter: STABLE_CYCLES, default 4, number of consecutive equal samples needed before a digit is accepted (legal 2..255).
REQ-002 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-003 Port reset, input, 1: asynchronous, active-high reset.
REQ-004 Port seg, input, 7: segment lines as [6:0]=gfedcba, active-low.
REQ-005 Port dp, input, 1: decimal point, active-low; sampled and ignored.
REQ-006 Port an, input, 4: digit anodes, active-low; an[3] is the leftmost digit, an[0] the rightmost.
REQ-007 Port data, output, 16: last published frame; nibble i holds digit i.
REQ-008 Port sign, output, 1: last published frame showed a minus on digit 3.
REQ-009 Port err, output, 1: last published frame contained an unrecognised pattern.
REQ-010 Port valid, output, 1: one-cycle pulse marking a new publish of data/sign/err.

Function
REQ-011 seg and an SHALL be registered every cycle into sample registers (s_seg, s_an).
REQ-012 Stability counter cnt: the block SHALL set cnt to 0 when the incoming seg/an differs from the sample; otherwise it SHALL increment cnt, saturating at STABLE_CYCLES.
REQ-013 Commit SHALL occur on the single edge where cnt reaches STABLE_CYCLES-1, with s_an having exactly one bit low; the block SHALL commit at most once per stable period.
REQ-014 No commit SHALL occur while s_an is 4'b1111 or has more than one bit low; err SHALL NOT be set in that case.
REQ-015 Decode table, seg to nibble:
- 1000000=0, 1111001=1, 0100100=2, 0110000=3
- 0011001=4, 0010010=5, 0000010=6, 1111000=7
- 0000000=8, 0010000=9, 0001000=A, 0000011=b
- 1000110=C, 0100001=d, 0000110=E, 0001110=F
REQ-016 On a digit-3 commit with seg=0111111, the block SHALL store nibble 0 and set the pending sign; on any other digit-3 commit it SHALL clear the pending sign.
REQ-017 A minus on digits 0-2, and any pattern not in REQ-015, SHALL store nibble 0 and set the pending error.
REQ-018 Each commit SHALL set seen[i] for the active digit; recommitting a digit before frame completion SHALL overwrite it (latest wins).
REQ-019 The state machine SHALL have two states, COLLECT and PUBLISH:
- COLLECT -> PUBLISH on the edge after seen becomes 4'b1111.
- PUBLISH lasts one cycle: valid=1, data/sign/err loaded from pending registers, then -> COLLECT.
- On leaving PUBLISH, seen, pending sign and pending error SHALL be cleared.
REQ-020 A commit coinding with the PUBLISH cycle SHALL belong to the new frame: its seen bit, nibble and flags SHALL survive the clear.
REQ-021 data, sign and err SHALL hold their values between publishes.
REQ-022 Latency: with constant inputs from edge 0, commit SHALL occur at edge STABLE_CYCLES-1+1 (sample edge included); valid SHALL rise one edge after the fourth digit's commit.

Reset
REQ-023 While reset is high:
- data=0, sign=0, err=0, valid=0
- state=COLLECT, seen=0, cnt=0
- pending nibbles and flags cleared
- s_seg=7'h7F, s_an=4'hF
REQ-024 Reset asserted mid-frame SHALL discard all partially collected digits; reset removal SHALL NOT produce valid until four new commits occur.

Verification
REQ-025 Scan 1,2,3,4 on an=1110,1101,1011,0111, each held 8 cycles, STABLE_CYCLES=4 -> single valid pulse, data=16'h4321, sign=0, err=0.
REQ-026 Digit 3 shows 0111111, digits 2..0 show 0,1,5 -> data=16'h0015, sign=1, err=0.
REQ-027 Digit 1 shows 1111111 -> err=1 and nibble 1=0 at publish; the next clean frame -> err=0.
REQ-028 seg toggles every 2 cycles on one digit -> no commit, no valid; an=0011 held 20 cycles -> no commit.
REQ-029 Reset pulse after 3 digits committed, then one digit -> no valid; then three more digits -> valid with only post-reset values.
REQ-030 Continuous scanning, where digit 0 of the next frame commits in the PUBLISH cycle -> next frame publishes correctly with that digit retained.
